// File: rtl/reg_scoreboard.sv
// reg_scoreboard: ID-stage RAW hazard scoreboard with saturating per-register pending-write counters.
// Address NUM_REGS and above (the PC) is never tracked and never hazards.
module reg_scoreboard #(
    parameter int NUM_REGS = 15,
    parameter int ADDR_W   = 4,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic                issue_wb_en,
    input  logic [ADDR_W-1:0]   issue_dest,
    input  logic [ADDR_W-1:0]   src1,
    input  logic [ADDR_W-1:0]   src2,
    input  logic                src2_used,
    input  logic                freeze,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_dest,
    input  logic                squash_valid,
    input  logic [ADDR_W-1:0]   squash_dest,
    output logic                hazard,
    output logic                issue_accept,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                sb_err
);
    localparam int W = CNT_W + 1;
    localparam logic [W-1:0] CNT_MAX = W'((1 << CNT_W) - 1);

    logic [2**ADDR_W-1:0] eff_nz;
    logic [NUM_REGS-1:0]  err_v;
    logic                 sb_err_q, sb_err_d;

    genvar g;
    for (g = 0; g < 2**ADDR_W; g++) begin : g_reg
        if (g < NUM_REGS) begin : g_trk
            logic [CNT_W-1:0] count_q, count_d;
            logic [W-1:0]     sum, sub, diff;
            logic             inc, ret, sq, under, over;
            assign inc   = issue_accept & (issue_dest == ADDR_W'(g));
            assign ret   = wb_valid & (wb_dest == ADDR_W'(g));
            assign sq    = squash_valid & (squash_dest == ADDR_W'(g));
            assign sum   = {1'b0, count_q} + W'(inc);
            assign sub   = W'(ret) + W'(sq);
            assign diff  = sum - sub;
            assign under = sum < sub;
            assign over  = !under && diff > CNT_MAX;
            // a same-cycle retire/squash already frees the data for this decode
            assign eff_nz[g] = {1'b0, count_q} > sub;
            assign err_v[g]  = under | over;
            assign count_d   = under ? '0 : over ? CNT_MAX[CNT_W-1:0] : diff[CNT_W-1:0];
            assign busy_mask[g] = |count_q;
            always_ff @(posedge clk) begin
                count_q <= rst ? '0 : count_d;
            end
        end else begin : g_pc
            assign eff_nz[g] = 1'b0;
        end
    end

    assign hazard       = issue_valid & (eff_nz[src1] | (src2_used & eff_nz[src2]));
    assign issue_accept = issue_valid & issue_wb_en & (int'(issue_dest) < NUM_REGS) & ~hazard & ~freeze;
    assign sb_err_d     = sb_err_q | (|err_v);
    assign sb_err       = sb_err_q;

    always_ff @(posedge clk) begin
        sb_err_q <= rst ? 1'b0 : sb_err_d;
    end
endmodule
